// File: rtl/gost_byte_loader.sv
// Byte-serial loader/unloader for the GOST 28147-89 core: assembles key and data block
// from byte writes, pulses load, then streams the 64-bit result back MSB byte first.
module gost_byte_loader #(
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   byte_in,
  input  logic         byte_valid,
  input  logic         sel_key,
  input  logic         clr,
  input  logic         start,
  input  logic         mode_in,
  input  logic         core_done,
  input  logic [63:0]  cdata,
  output logic [255:0] key,
  output logic [63:0]  pdata,
  output logic         mode,
  output logic         load,
  output logic [7:0]   byte_out,
  output logic         out_valid,
  input  logic         out_ack,
  output logic         key_full,
  output logic         data_full,
  output logic         busy,
  output logic         timeout
);

  localparam int unsigned WW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WW-1:0] TO_LAST = WW'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);
  localparam bit TO_EN = (TIMEOUT_CYC != 0);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, OUT} state_e;

  state_e         state_q, state_d;
  logic [255:0]   key_q, key_d;
  logic [63:0]    pdata_q, pdata_d;
  logic [63:0]    oreg_q, oreg_d;
  logic [5:0]     kcnt_q, kcnt_d;
  logic [3:0]     dcnt_q, dcnt_d;
  logic [2:0]     ocnt_q, ocnt_d;
  logic [WW-1:0]  wcnt_q, wcnt_d;
  logic           mode_q, mode_d;
  logic           timeout_q, timeout_d;

  logic startOk;
  logic waitExpired;
  logic lastAck;

  assign key_full    = (kcnt_q == 6'd32);
  assign data_full   = (dcnt_q == 4'd8);
  assign startOk     = start && key_full && data_full;
  assign waitExpired = TO_EN && (wcnt_q == TO_LAST);
  assign lastAck     = out_ack && (ocnt_q == 3'd7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (!clr && startOk) state_d = LOAD;
      LOAD: state_d = WAIT;
      WAIT: begin
        if (core_done)        state_d = OUT;
        else if (waitExpired) state_d = IDLE;
      end
      OUT:  if (lastAck) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load      = (state_q == LOAD);
    out_valid = (state_q == OUT);
    busy      = (state_q != IDLE);
  end

  assign key      = key_q;
  assign pdata    = pdata_q;
  assign mode     = mode_q;
  assign timeout  = timeout_q;
  assign byte_out = oreg_q[63:56];

  // Datapath next-state; byte writes and clr only act in IDLE so key/pdata/mode stay frozen mid-op.
  always_comb begin
    key_d     = key_q;
    pdata_d   = pdata_q;
    oreg_d    = oreg_q;
    kcnt_d    = kcnt_q;
    dcnt_d    = dcnt_q;
    ocnt_d    = ocnt_q;
    wcnt_d    = wcnt_q;
    mode_d    = mode_q;
    timeout_d = timeout_q;
    case (state_q)
      IDLE: begin
        if (clr) begin
          kcnt_d = 6'd0;
          dcnt_d = 4'd0;
        end else begin
          if (byte_valid) begin
            if (sel_key && !key_full) begin
              key_d  = {key_q[247:0], byte_in};
              kcnt_d = kcnt_q + 6'd1;
            end else if (!sel_key && !data_full) begin
              pdata_d = {pdata_q[55:0], byte_in};
              dcnt_d  = dcnt_q + 4'd1;
            end
          end
          if (startOk) begin
            mode_d    = mode_in;
            timeout_d = 1'b0;
          end
        end
      end
      LOAD: wcnt_d = '0;
      WAIT: begin
        wcnt_d = wcnt_q + WW'(1);
        if (core_done) begin
          oreg_d = cdata;
          ocnt_d = 3'd0;
        end else if (waitExpired) begin
          timeout_d = 1'b1;
          dcnt_d    = 4'd0;
        end
      end
      OUT: begin
        if (out_ack) begin
          oreg_d = {oreg_q[55:0], 8'h00};
          ocnt_d = ocnt_q + 3'd1;
          if (ocnt_q == 3'd7) dcnt_d = 4'd0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q     <= '0;
      pdata_q   <= '0;
      oreg_q    <= '0;
      kcnt_q    <= '0;
      dcnt_q    <= '0;
      ocnt_q    <= '0;
      wcnt_q    <= '0;
      mode_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      key_q     <= key_d;
      pdata_q   <= pdata_d;
      oreg_q    <= oreg_d;
      kcnt_q    <= kcnt_d;
      dcnt_q    <= dcnt_d;
      ocnt_q    <= ocnt_d;
      wcnt_q    <= wcnt_d;
      mode_q    <= mode_d;
      timeout_q <= timeout_d;
    end
  end

endmodule
